// File: rtl/clock_meter_pkg.sv
// Shared types and derived-constant helpers for clock_meter.
// Build option CLOCK_METER_JITTER_EN is consumed by clock_meter.sv.
package clock_meter_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Expected window sum: round(clk_src / clk_div * 2^avg_log2).
  function automatic int calc_exp_sum(input real clk_src, input real clk_div,
                                      input int unsigned avg_log2);
    real scale;
    scale = real'(32'd1 << avg_log2);
    return $rtoi((clk_src / clk_div) * scale + 0.5);
  endfunction

  // Four nominal periods without an edge count as loss of clock.
  function automatic int calc_timeout(input real clk_src, input real clk_div);
    return 4 * $rtoi(clk_src / clk_div);
  endfunction

  function automatic int calc_pw(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic int calc_w(input int pw, input int unsigned avg_log2);
    return pw + int'(avg_log2);
  endfunction

endpackage

// File: rtl/clock_meter_sync.sv
// Two-flop synchronizer plus history flop; emits a one-cycle rising-edge pulse.
module clock_meter_sync (
  input  logic clk_src,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk_src) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/clock_meter.sv
// Period meter for an asynchronous clock: windowed period sum, lock flag and
// optional per-window min/max period (build option CLOCK_METER_JITTER_EN).
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter real         CLK_SRC  = 135.0,
  parameter real         CLK_DIV  = 3.6,
  parameter int unsigned AVG_LOG2 = 8,
  parameter int unsigned TOL_SUM  = 64,
  localparam int         TIMEOUT  = calc_timeout(CLK_SRC, CLK_DIV),
  localparam int         PW       = calc_pw(TIMEOUT),
  localparam int         W        = calc_w(PW, AVG_LOG2)
) (
  input  logic          clk_src,
  input  logic          rst,
  input  logic          clk_in,
  output logic          edge_strobe,
  output logic [W-1:0]  period_sum,
  output logic          sum_valid,
  output logic          locked
`ifdef CLOCK_METER_JITTER_EN
  ,
  output logic [PW-1:0] period_min,
  output logic [PW-1:0] period_max
`endif
);

  localparam int              EXP_SUM      = calc_exp_sum(CLK_SRC, CLK_DIV, AVG_LOG2);
  localparam logic [PW-1:0]   TIMEOUT_LAST = PW'(TIMEOUT - 1);
  localparam logic [W-1:0]    EXP_W        = W'(EXP_SUM);
  localparam logic [W-1:0]    TOL_W        = W'(TOL_SUM);

  state_t              state;
  logic                rise;
  logic [PW-1:0]       pcnt;
  logic [AVG_LOG2-1:0] wcnt;
  logic [W-1:0]        acc;

  logic [PW-1:0]       sample;
  logic [W-1:0]        sum_next;
  logic [W-1:0]        sum_diff;
  logic                window_done;

  clock_meter_sync u_sync (
    .clk_src  (clk_src),
    .rst      (rst),
    .async_in (clk_in),
    .rise     (rise)
  );

  assign sample      = pcnt + 1'b1;
  assign sum_next    = acc + W'(sample);
  assign window_done = (wcnt == '1);
  // Unsigned distance from the expected sum, larger minus smaller.
  assign sum_diff    = (sum_next >= EXP_W) ? (sum_next - EXP_W) : (EXP_W - sum_next);

`ifdef CLOCK_METER_JITTER_EN
  logic [PW-1:0] cur_min;
  logic [PW-1:0] cur_max;
  logic [PW-1:0] win_min;
  logic [PW-1:0] win_max;

  assign win_min = (sample < cur_min) ? sample : cur_min;
  assign win_max = (sample > cur_max) ? sample : cur_max;
`endif

  always_ff @(posedge clk_src) begin
    if (rst) begin
      state       <= IDLE;
      pcnt        <= '0;
      wcnt        <= '0;
      acc         <= '0;
      edge_strobe <= 1'b0;
      sum_valid   <= 1'b0;
      locked      <= 1'b0;
      period_sum  <= '0;
`ifdef CLOCK_METER_JITTER_EN
      cur_min     <= '1;
      cur_max     <= '0;
      period_min  <= '1;
      period_max  <= '0;
`endif
    end else begin
      edge_strobe <= rise;
      sum_valid   <= 1'b0;
      pcnt        <= rise ? '0 : pcnt + 1'b1;

      case (state)
        IDLE: begin
          // First edge only aligns the period counter.
          if (rise) state <= RUN;
        end
        RUN: begin
          if (rise) begin
            wcnt <= wcnt + 1'b1;
            if (window_done) begin
              period_sum <= sum_next;
              acc        <= '0;
              sum_valid  <= 1'b1;
              locked     <= (sum_diff <= TOL_W);
`ifdef CLOCK_METER_JITTER_EN
              period_min <= win_min;
              period_max <= win_max;
              cur_min    <= '1;
              cur_max    <= '0;
`endif
            end else begin
              acc <= sum_next;
`ifdef CLOCK_METER_JITTER_EN
              cur_min <= win_min;
              cur_max <= win_max;
`endif
            end
          end else if (pcnt == TIMEOUT_LAST) begin
            state  <= IDLE;
            locked <= 1'b0;
            acc    <= '0;
            wcnt   <= '0;
            pcnt   <= '0;
`ifdef CLOCK_METER_JITTER_EN
            cur_min <= '1;
            cur_max <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_meter.sv
// Directed bench for clock_meter with default parameters (EXP_SUM 9600, TIMEOUT 148).
module tb_clock_meter;

  logic        clk;
  logic        rst;
  logic        clk_in;
  logic        edge_strobe;
  logic [15:0] period_sum;
  logic        sum_valid;
  logic        locked;
`ifdef CLOCK_METER_JITTER_EN
  logic [7:0]  period_min;
  logic [7:0]  period_max;
`endif

  int tests = 0;
  int fails = 0;
  int sv_cnt = 0;
  int strobe_cnt = 0;

  clock_meter #(
    .CLK_SRC  (135.0),
    .CLK_DIV  (3.6),
    .AVG_LOG2 (8),
    .TOL_SUM  (64)
  ) dut (
    .clk_src     (clk),
    .rst         (rst),
    .clk_in      (clk_in),
    .edge_strobe (edge_strobe),
    .period_sum  (period_sum),
    .sum_valid   (sum_valid),
    .locked      (locked)
`ifdef CLOCK_METER_JITTER_EN
    ,
    .period_min  (period_min),
    .period_max  (period_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (sum_valid === 1'b1) sv_cnt++;
    if (edge_strobe === 1'b1) strobe_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int alt(input int k);
    return (k % 2 == 1) ? 37 : 38;
  endfunction

  // One rising edge of clk_in, next edge p cycles later.
  task automatic send_period(input int p);
    clk_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    clk_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic send_alt(input int first, input int last);
    for (int k = first; k <= last; k++) send_period(alt(k));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++; if (edge_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %0b expected 0", edge_strobe); end
    tests++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", sum_valid); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    tests++; if (period_sum !== 16'd0) begin fails++; $display("FAIL reset_sum: got %0d expected 0", period_sum); end
`ifdef CLOCK_METER_JITTER_EN
    tests++; if (period_min !== 8'hFF) begin fails++; $display("FAIL reset_min: got %0d expected 255", period_min); end
    tests++; if (period_max !== 8'd0) begin fails++; $display("FAIL reset_max: got %0d expected 0", period_max); end
`endif
  endtask

  task automatic test_edge_strobe();
    logic exp_s [4];
    exp_s = '{1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    clk_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (edge_strobe !== exp_s[i]) begin
        fails++; $display("FAIL strobe_cycle%0d: got %0b expected %0b", i + 1, edge_strobe, exp_s[i]);
      end
    end
    @(negedge clk);
    clk_in = 1'b0;
    repeat (200) @(negedge clk);
  endtask

  task automatic test_lock();
    int sv0, st0;
    @(negedge clk);
    sv0 = sv_cnt;
    st0 = strobe_cnt;
    send_alt(1, 256);
    tests++; if (sv_cnt - sv0 !== 0) begin fails++; $display("FAIL lock_early_valid: got %0d pulses expected 0", sv_cnt - sv0); end
    send_alt(257, 257);
    tests++; if (sv_cnt - sv0 !== 1) begin fails++; $display("FAIL lock_valid_count: got %0d expected 1", sv_cnt - sv0); end
    tests++; if (period_sum !== 16'd9600) begin fails++; $display("FAIL lock_sum: got %0d expected 9600", period_sum); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_locked: got %0b expected 1", locked); end
    tests++; if (strobe_cnt - st0 !== 257) begin fails++; $display("FAIL lock_strobe_count: got %0d expected 257", strobe_cnt - st0); end
  endtask

  task automatic test_reset_mid();
    int sv0;
    send_alt(258, 357);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL mid_pre_locked: got %0b expected 1", locked); end
    pulse_reset();
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL mid_locked: got %0b expected 0", locked); end
    tests++; if (period_sum !== 16'd0) begin fails++; $display("FAIL mid_sum: got %0d expected 0", period_sum); end
    tests++; if (sum_valid !== 1'b0 || edge_strobe !== 1'b0) begin
      fails++; $display("FAIL mid_pulses: got valid=%0b strobe=%0b expected 0 0", sum_valid, edge_strobe);
    end
    sv0 = sv_cnt;
    send_alt(1, 256);
    tests++; if (sv_cnt - sv0 !== 0) begin fails++; $display("FAIL mid_early_valid: got %0d expected 0", sv_cnt - sv0); end
    send_alt(257, 257);
    tests++; if (sv_cnt - sv0 !== 1) begin fails++; $display("FAIL mid_valid_count: got %0d expected 1", sv_cnt - sv0); end
    tests++; if (period_sum !== 16'd9600) begin fails++; $display("FAIL mid_resume_sum: got %0d expected 9600", period_sum); end
  endtask

  task automatic test_timeout();
    int sv0;
    bit found;
    pulse_reset();
    sv0 = sv_cnt;
    send_alt(1, 256);
    clk_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      if (edge_strobe === 1'b1) found = 1'b1;
    end
    tests++; if (!found) begin fails++; $display("FAIL timeout_last_edge: got no strobe expected strobe within 10 cycles"); end
    repeat (147) @(posedge clk);
    #1;
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL timeout_hold_147: got %0b expected 1", locked); end
    @(posedge clk);
    #1;
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL timeout_drop_148: got %0b expected 0", locked); end
    tests++; if (sv_cnt - sv0 !== 1) begin fails++; $display("FAIL timeout_no_valid: got %0d pulses expected 1", sv_cnt - sv0); end
    tests++; if (period_sum !== 16'd9600) begin fails++; $display("FAIL timeout_sum_hold: got %0d expected 9600", period_sum); end
    @(negedge clk);
    clk_in = 1'b0;
    repeat (5) @(negedge clk);
    sv0 = sv_cnt;
    send_alt(1, 256);
    tests++; if (sv_cnt - sv0 !== 0 || locked !== 1'b0) begin
      fails++; $display("FAIL relock_early: got pulses=%0d locked=%0b expected 0 0", sv_cnt - sv0, locked);
    end
    send_alt(257, 257);
    tests++; if (sv_cnt - sv0 !== 1 || locked !== 1'b1 || period_sum !== 16'd9600) begin
      fails++; $display("FAIL relock: got pulses=%0d locked=%0b sum=%0d expected 1 1 9600", sv_cnt - sv0, locked, period_sum);
    end
  endtask

  task automatic test_constant_40();
    int sv0;
    sv0 = sv_cnt;
    // First window still carries the 37-tick interval left by the previous stream.
    for (int k = 0; k < 255; k++) send_period(40);
    tests++; if (sv_cnt - sv0 !== 0) begin fails++; $display("FAIL c40_early: got %0d expected 0", sv_cnt - sv0); end
    send_period(40);
    tests++; if (sv_cnt - sv0 !== 1 || period_sum !== 16'd10237 || locked !== 1'b0) begin
      fails++; $display("FAIL c40_first: got pulses=%0d sum=%0d locked=%0b expected 1 10237 0", sv_cnt - sv0, period_sum, locked);
    end
    sv0 = sv_cnt;
    for (int k = 0; k < 256; k++) send_period(40);
    tests++; if (sv_cnt - sv0 !== 1) begin fails++; $display("FAIL c40_repeat: got %0d expected 1", sv_cnt - sv0); end
    tests++; if (period_sum !== 16'd10240) begin fails++; $display("FAIL c40_sum: got %0d expected 10240", period_sum); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL c40_locked: got %0b expected 0", locked); end
  endtask

  task automatic test_timeout_boundary();
    int sv0;
    pulse_reset();
    sv0 = sv_cnt;
    send_period(148);
    for (int k = 1; k <= 255; k++) send_period(alt(k));
    tests++; if (sv_cnt - sv0 !== 0) begin fails++; $display("FAIL edge148_early: got %0d expected 0", sv_cnt - sv0); end
    send_period(37);
    tests++; if (sv_cnt - sv0 !== 1) begin fails++; $display("FAIL edge148_stay_run: got %0d pulses expected 1", sv_cnt - sv0); end
    tests++; if (period_sum !== 16'd9710) begin fails++; $display("FAIL edge148_sum: got %0d expected 9710", period_sum); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL edge148_locked: got %0b expected 0", locked); end
  endtask

`ifdef CLOCK_METER_JITTER_EN
  task automatic test_jitter();
    int sv0;
    pulse_reset();
    sv0 = sv_cnt;
    for (int k = 1; k <= 257; k++) send_period(36 + (k - 1) % 4);
    tests++; if (sv_cnt - sv0 !== 1) begin fails++; $display("FAIL jit_valid: got %0d expected 1", sv_cnt - sv0); end
    tests++; if (period_sum !== 16'd9600) begin fails++; $display("FAIL jit_sum: got %0d expected 9600", period_sum); end
    tests++; if (period_min !== 8'd36) begin fails++; $display("FAIL jit_min: got %0d expected 36", period_min); end
    tests++; if (period_max !== 8'd39) begin fails++; $display("FAIL jit_max: got %0d expected 39", period_max); end
  endtask
`endif

  initial begin
    test_reset();
    test_edge_strobe();
    test_lock();
    test_reset_mid();
    test_timeout();
    test_constant_40();
    test_timeout_boundary();
`ifdef CLOCK_METER_JITTER_EN
    test_jitter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
